div_unit: RTL

Multi-cycle unsigned radix-2 restoring divider; the responder on the execute stage's valid/done divide handshake. The execute stage drives `valid` with magnitude operands (sign fix-up stays in the execute stage), holds the pipeline stalled until `done`, then consumes `c = {remainder, quotient}` into HI/LO. Fixed latency, one operation in flight, level-sensitive request.

---
 rtl/div_unit_pkg.sv | 16 +
 rtl/div_unit_step.sv | 27 ++
 rtl/div_unit.sv | 80 ++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared types for the divide unit.
// Word typedefs and the divider state encoding.
package div_unit_pkg;

  localparam int XLEN = 32;

  typedef logic [31:0] i32;
  typedef logic [63:0] i64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring division iteration.
// Swap point for wider-radix variants.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH:0]   trial;

  // Shift, trial-subtract, restore on borrow.
  always_comb begin
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    quo_sh = {acc[WIDTH-2:0], 1'b0};
    trial  = rem_sh - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      acc_next = {trial[WIDTH-1:0], quo_sh[WIDTH-1:1], 1'b1};
    end else begin
      acc_next = {rem_sh[WIDTH-1:0], quo_sh};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle unsigned restoring divider.
// Level request, fixed latency, one op in flight.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_t         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   divisor;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc),
    .divisor (divisor),
    .acc_next(acc_next)
  );

  // Control FSM with registered done/c.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      divisor <= '0;
      acc     <= '0;
      done    <= 1'b0;
      c       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (valid) begin
            divisor <= b;
            acc     <= {{WIDTH{1'b0}}, a};
            cnt     <= CNT_LOAD;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!valid) begin
            state <= IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              c     <= acc_next;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
